// File: rtl/uart_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_pkg
//   Shared types and constants for the UART frame collector.
//   frame_st_t  : collector FSM state encoding.
//   OVR_CNT_MAX : saturation value of the overrun byte counter.
// -----------------------------------------------------------------------------
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DROP  = 2'd2,
    READY = 2'd3
  } frame_st_t;

  localparam logic [7:0] OVR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/uart_frame_ram.sv
// -----------------------------------------------------------------------------
// uart_frame_ram
//   DEPTH x 8 simple dual-port frame buffer: one write port, one registered
//   read port (1-cycle latency). The read register clears on reset; the
//   storage array is never cleared.
// Ports
//   clk      in   1        system clock
//   reset    in   1        synchronous, active-low; clears rd_data only
//   wr_en    in   1        write strobe
//   wr_addr  in   ADDR_W   write address
//   wr_data  in   8        write data
//   rd_addr  in   ADDR_W   read address
//   rd_data  out  8        mem[rd_addr], registered
// -----------------------------------------------------------------------------
module uart_frame_ram
  import uart_frame_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register stage: output settles one cycle after rd_addr.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_frame_collector.sv
// -----------------------------------------------------------------------------
// uart_frame_collector
//   Gathers bytes from the UART receiver into a frame buffer and closes the
//   frame when the idle detector reports a line timeout. A closed frame is
//   frozen and presented to the consumer with frame_ready until frame_ack.
//   Frames longer than MAX_LEN or shorter than MIN_LEN are discarded with a
//   one-cycle frame_drop pulse. Bytes arriving while a frame is held are
//   lost and counted in a saturating overrun counter.
// Ports
//   clk          in   1          system clock
//   reset        in   1          synchronous, active-low (0 = reset)
//   rx_data      in   8          received byte, valid with rx_done
//   rx_done      in   1          1-cycle pulse: byte received
//   parity_err   in   1          qualifies rx_done: byte had a parity error
//   timeout      in   1          1-cycle pulse: line idle
//   frame_ready  out  1          frame complete, buffer frozen until frame_ack
//   frame_len    out  ADDR_W+1   byte count of the ready frame
//   frame_perr   out  1          at least one byte of the frame had bad parity
//   frame_ack    in   1          consumer done, releases the buffer
//   rd_addr      in   ADDR_W     read address into the frame buffer
//   rd_data      out  8          buffer[rd_addr], 1-cycle latency
//   frame_drop   out  1          1-cycle pulse: frame discarded
//   overrun_cnt  out  8          saturating count of bytes lost while ready
// -----------------------------------------------------------------------------
module uart_frame_collector
  import uart_frame_pkg::*;
#(
  parameter  int MAX_LEN = 256,
  parameter  int MIN_LEN = 1,
  localparam int ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              parity_err,
  input  logic              timeout,
  output logic              frame_ready,
  output logic [ADDR_W:0]   frame_len,
  output logic              frame_perr,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_drop,
  output logic [7:0]        overrun_cnt
);

  // wr_cnt is one bit wider than the address so a full buffer (MAX_LEN)
  // is representable and distinguishable from an empty one.
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0] LEN_MIN = (ADDR_W+1)'(MIN_LEN);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  frame_st_t         state, state_nxt;
  logic [ADDR_W:0]   wr_cnt, wr_cnt_nxt;
  logic              perr, perr_nxt;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  // Count / parity after accepting this cycle's byte; a timeout arriving
  // together with a byte is judged against these, not the old values.
  logic [ADDR_W:0]   cnt_eff;
  logic              perr_eff;

  logic              load_frame;
  logic              drop_pulse;
  logic              release_frame;
  logic              count_ovr;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == OVR_CNT_MAX) ? v : v + 8'd1;
  endfunction

  // Next-state / write-control decode.
  always_comb begin
    state_nxt     = state;
    wr_cnt_nxt    = wr_cnt;
    perr_nxt      = perr;
    wr_en         = 1'b0;
    wr_addr       = wr_cnt[ADDR_W-1:0];
    cnt_eff       = wr_cnt;
    perr_eff      = perr;
    load_frame    = 1'b0;
    drop_pulse    = 1'b0;
    release_frame = 1'b0;
    count_ovr     = 1'b0;

    case (state)
      IDLE: begin
        // A lone timeout with no bytes pending is just line idle.
        if (rx_done) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          wr_cnt_nxt = CNT_ONE;
          perr_nxt   = parity_err;
          state_nxt  = RECV;
        end
      end

      RECV: begin
        if (rx_done && (wr_cnt >= LEN_MAX)) begin
          // Overflowing byte: any simultaneous timeout is swallowed, the
          // next timeout ends the discarded frame.
          state_nxt = DROP;
        end else begin
          if (rx_done) begin
            wr_en    = 1'b1;
            cnt_eff  = wr_cnt + CNT_ONE;
            perr_eff = perr | parity_err;
          end
          wr_cnt_nxt = cnt_eff;
          perr_nxt   = perr_eff;
          if (timeout) begin
            if (cnt_eff >= LEN_MIN) begin
              load_frame = 1'b1;
              state_nxt  = READY;
            end else begin
              drop_pulse = 1'b1;
              state_nxt  = IDLE;
            end
          end
        end
      end

      DROP: begin
        if (timeout) begin
          drop_pulse = 1'b1;
          state_nxt  = IDLE;
        end
      end

      READY: begin
        // Buffer is frozen; every arriving byte is lost, including one
        // coinciding with the acknowledge.
        count_ovr = rx_done;
        if (frame_ack) begin
          release_frame = 1'b1;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control register stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      perr        <= 1'b0;
      frame_ready <= 1'b0;
      frame_len   <= '0;
      frame_perr  <= 1'b0;
      frame_drop  <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state      <= state_nxt;
      wr_cnt     <= wr_cnt_nxt;
      perr       <= perr_nxt;
      frame_drop <= drop_pulse;
      if (load_frame) begin
        frame_ready <= 1'b1;
        frame_len   <= cnt_eff;
        frame_perr  <= perr_eff;
      end else if (release_frame) begin
        frame_ready <= 1'b0;
      end
      if (count_ovr) begin
        overrun_cnt <= sat_inc8(overrun_cnt);
      end
    end
  end

  uart_frame_ram #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_uart_frame_collector.sv
module tb_uart_frame_collector;

  localparam int MAX_LEN = 4;
  localparam int MIN_LEN = 1;
  localparam int ADDR_W  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_done = 1'b0;
  logic              parity_err = 1'b0;
  logic              timeout = 1'b0;
  logic              frame_ready;
  logic [ADDR_W:0]   frame_len;
  logic              frame_perr;
  logic              frame_ack = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [7:0]        rd_data;
  logic              frame_drop;
  logic [7:0]        overrun_cnt;

  always #50 clk = ~clk;

  uart_frame_collector #(
    .MAX_LEN (MAX_LEN),
    .MIN_LEN (MIN_LEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .parity_err  (parity_err),
    .timeout     (timeout),
    .frame_ready (frame_ready),
    .frame_len   (frame_len),
    .frame_perr  (frame_perr),
    .frame_ack   (frame_ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_drop  (frame_drop),
    .overrun_cnt (overrun_cnt)
  );

  typedef struct {
    bit       drop;
    int       len;
    bit       perr;
    bit [7:0] b [MAX_LEN];
  } exp_t;

  exp_t     sb [$];
  bit [7:0] cur_b [$];
  bit       cur_perr;
  bit       in_frame;
  bit       ovf;
  bit       ready_exp;
  int       exp_ovr;
  exp_t     last_frame;

  int checks = 0;
  int failures = 0;
  int drop_seen = 0;

  always @(posedge clk) begin
    if (frame_drop) drop_seen <= drop_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns 1 when this byte is the one that overflows.
  function automatic bit model_byte(input bit [7:0] b, input bit pe);
    if (ready_exp) begin
      exp_ovr = (exp_ovr >= 255) ? 255 : exp_ovr + 1;
      return 1'b0;
    end
    if (!in_frame) begin
      in_frame = 1'b1;
      ovf      = 1'b0;
      cur_perr = 1'b0;
      cur_b.delete();
    end
    if (ovf) return 1'b0;
    if (cur_b.size() < MAX_LEN) begin
      cur_b.push_back(b);
      cur_perr = cur_perr | pe;
      return 1'b0;
    end
    ovf = 1'b1;
    return 1'b1;
  endfunction

  function automatic void model_timeout();
    exp_t e;
    if (ready_exp || !in_frame) return;
    e.drop = ovf || (cur_b.size() < MIN_LEN);
    e.len  = cur_b.size();
    e.perr = cur_perr;
    for (int i = 0; i < MAX_LEN; i++) e.b[i] = (i < cur_b.size()) ? cur_b[i] : 8'h00;
    sb.push_back(e);
    if (!e.drop) ready_exp = 1'b1;
    in_frame = 1'b0;
  endfunction

  task automatic send(input bit [7:0] b, input bit pe, input bit to, input bit ack);
    bit nov;
    @(negedge clk);
    rx_data    = b;
    rx_done    = 1'b1;
    parity_err = pe;
    timeout    = to;
    frame_ack  = ack;
    nov = model_byte(b, pe);
    if (to && !nov) model_timeout();
    if (ack) ready_exp = 1'b0;
    @(negedge clk);
    rx_done    = 1'b0;
    parity_err = 1'b0;
    timeout    = 1'b0;
    frame_ack  = 1'b0;
  endtask

  task automatic idle_to();
    @(negedge clk);
    timeout = 1'b1;
    model_timeout();
    @(negedge clk);
    timeout = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk);
    frame_ack = 1'b1;
    ready_exp = 1'b0;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic read_back(input string tag, input exp_t e);
    for (int i = 0; i < e.len; i++) begin
      rd_addr = i[ADDR_W-1:0];
      @(negedge clk);
      chk($sformatf("%s rd_data[%0d]", tag, i), rd_data, e.b[i]);
    end
  endtask

  task automatic expect_event(input string tag);
    exp_t e;
    int   n = 0;
    while (!frame_ready && !frame_drop && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk({tag, " event_wait_expired"}, 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk({tag, " unexpected_event"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, " frame_drop"}, frame_drop, e.drop);
    chk({tag, " frame_ready"}, frame_ready, !e.drop);
    if (!e.drop) begin
      chk({tag, " frame_len"}, frame_len, e.len);
      chk({tag, " frame_perr"}, frame_perr, e.perr);
      last_frame = e;
      read_back(tag, e);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " frame_ready"}, frame_ready, 0);
    chk({tag, " frame_len"}, frame_len, 0);
    chk({tag, " frame_perr"}, frame_perr, 0);
    chk({tag, " frame_drop"}, frame_drop, 0);
    chk({tag, " overrun_cnt"}, overrun_cnt, 0);
    chk({tag, " rd_data"}, rd_data, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal;
  end

  initial begin
    int d0;
    in_frame = 0; ovf = 0; ready_exp = 0; exp_ovr = 0; cur_perr = 0;

    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    reset = 1'b1;

    // Idle-line timeout and stray ack with nothing pending do nothing.
    idle_to();
    do_ack();
    repeat (2) @(negedge clk);
    chk("idle_timeout ready", frame_ready, 0);
    chk("idle_timeout drops", drop_seen, 0);

    // Three-byte frame.
    send(8'h53, 0, 0, 0);
    send(8'h9B, 0, 0, 0);
    send(8'h46, 0, 0, 0);
    idle_to();
    expect_event("t1");

    // Ack, then a single-byte frame.
    do_ack();
    chk("t2 ready_after_ack", frame_ready, 0);
    send(8'h11, 0, 0, 0);
    idle_to();
    expect_event("t2");
    do_ack();

    // Five bytes into a four-byte buffer: one drop, then a fresh frame.
    d0 = drop_seen;
    for (int i = 1; i <= 5; i++) send(i[7:0], 0, 0, 0);
    idle_to();
    expect_event("t3");
    repeat (3) @(negedge clk);
    chk("t3 drop_count", drop_seen - d0, 1);
    chk("t3 ready_stays_low", frame_ready, 0);
    send(8'hA5, 0, 0, 0);
    idle_to();
    expect_event("t3b");

    // Byte while a frame is held: counted, frame untouched.
    send(8'hAA, 0, 0, 0);
    chk("t4 overrun_cnt", overrun_cnt, exp_ovr);
    chk("t4 frame_ready", frame_ready, 1);
    chk("t4 frame_len", frame_len, last_frame.len);
    read_back("t4", last_frame);

    // Byte coinciding with ack is lost and counted.
    send(8'h77, 0, 0, 1);
    chk("ack_byte ready", frame_ready, 0);
    chk("ack_byte overrun_cnt", overrun_cnt, exp_ovr);

    // Parity error on the middle byte.
    send(8'h10, 0, 0, 0);
    send(8'h20, 1, 0, 0);
    send(8'h30, 0, 0, 0);
    idle_to();
    expect_event("t5");
    do_ack();

    // Overflowing byte with simultaneous timeout: timeout swallowed.
    for (int i = 0; i < 4; i++) send(8'hB0 + i[7:0], 0, 0, 0);
    d0 = drop_seen;
    send(8'hB4, 0, 1, 0);
    repeat (2) @(negedge clk);
    chk("ovf_to drops_before", drop_seen - d0, 0);
    chk("ovf_to ready", frame_ready, 0);
    idle_to();
    expect_event("ovf_to");

    // Exactly MAX_LEN bytes is a valid frame.
    for (int i = 0; i < 4; i++) send(8'hC1 + i[7:0], 0, 0, 0);
    idle_to();
    expect_event("full");
    do_ack();

    // Reset mid-frame abandons it silently.
    send(8'h01, 0, 0, 0);
    send(8'h02, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    in_frame = 0; ovf = 0; ready_exp = 0; exp_ovr = 0;
    sb.delete();
    @(negedge clk);
    chk_zero_outputs("t6 reset");
    reset = 1'b1;
    send(8'h7E, 0, 0, 0);
    send(8'h3C, 0, 1, 0);
    expect_event("t6");

    // Overrun counter saturates.
    for (int i = 0; i < 260; i++) send(i[7:0], 0, 0, 0);
    chk("sat overrun_cnt", overrun_cnt, exp_ovr);
    chk("sat frame_len", frame_len, last_frame.len);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
